garo_move_unit: RTL and testbench

- Random-source and move-lookup block for the battle datapath.
- Six independent pseudo-random bit channels, modelled in RTL as Galois LFSRs, stand in for GARO instances:
  - 2 channels form the AI move.
  - 4 channels form the accuracy roll.
- A trainer select picks the player's or the AI's move; a fixed move table (move_mux function) returns its damage and accuracy plus a hit flag.
- Feeds the HP-update logic of the datapath.

---
 rtl/garo_move_unit.sv | 117 +++++++++++
 tb/tb_garo_move_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/garo_move_unit.sv
// rtl/garo_move_unit.sv - random-source and move-lookup block for the battle datapath
//
// Six independent Galois LFSR channels stand in for GARO entropy sources.
// Channels 0-1 form the AI move and channels 2-5 form the accuracy roll.
// A trainer select chooses the player's or the AI's move, and a fixed move
// table returns its damage, accuracy and a hit flag for the HP-update logic.
//
// Ports:
//   clk      in   1  system clock, all state on rising edge
//   rst      in   1  synchronous reset, active-high (overrides stop)
//   stop     in   1  1 = freeze all generator channels
//   actr     in   1  trainer select: 0 = player move, 1 = AI move
//   p_move   in   2  player's chosen move index
//   ai_move  out  2  random AI move {ch1, ch0}
//   accu_rng out  4  random accuracy roll {ch5, ch4, ch3, ch2}
//   sel_move out  2  move index in effect
//   dmg      out  4  damage of sel_move
//   accu     out  4  accuracy of sel_move
//   hit      out  1  1 when accu_rng <= accu

module garo_move_unit #(
    parameter int          LFSR_W = 16,
    parameter logic [15:0] POLY   = 16'hB400,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stop,
    input  logic       actr,
    input  logic [1:0] p_move,
    output logic [1:0] ai_move,
    output logic [3:0] accu_rng,
    output logic [1:0] sel_move,
    output logic [3:0] dmg,
    output logic [3:0] accu,
    output logic       hit
);

    localparam int N_CH = 6;

    // Channel 0 keeps the base seed so ai_move[0] is known right after reset;
    // the others are decorrelated by XORing a per-channel constant.  A zero
    // seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] seed_of(input int k);
        logic [LFSR_W-1:0] s;
        if (k == 0) begin
            s = LFSR_W'(SEED);
        end else begin
            s = LFSR_W'(SEED) ^ LFSR_W'(32'h1111 * (k + 1));
        end
        if (s == '0) begin
            s = LFSR_W'(1);
        end
        return s;
    endfunction

    // One right-shifting Galois step; feedback applied when the shifted-out
    // bit is 1, which keeps a nonzero state nonzero.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        if (s[0]) begin
            return (s >> 1) ^ LFSR_W'(POLY);
        end
        return s >> 1;
    endfunction

    // Fixed move table, packed as {dmg, accu}.
    function automatic logic [7:0] move_mux(input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = {4'd4,  4'd15};
            2'd1:    r = {4'd6,  4'd12};
            2'd2:    r = {4'd8,  4'd9};
            default: r = {4'd11, 4'd6};
        endcase
        return r;
    endfunction

    logic [N_CH-1:0][LFSR_W-1:0] state_q;
    logic [N_CH-1:0][LFSR_W-1:0] state_d;
    logic [N_CH-1:0][LFSR_W-1:0] seed_vec;
    logic [7:0]                  move_entry;

    always_comb begin
        seed_vec = '0;
        for (int k = 0; k < N_CH; k++) begin
            seed_vec[k] = seed_of(k);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!stop) begin
            for (int k = 0; k < N_CH; k++) begin
                state_d[k] = lfsr_step(state_q[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed_vec;
        end else begin
            state_q <= state_d;
        end
    end

    // Random bits come straight from the registers: no extra latency.
    assign ai_move  = {state_q[1][0], state_q[0][0]};
    assign accu_rng = {state_q[5][0], state_q[4][0], state_q[3][0], state_q[2][0]};

    assign sel_move   = actr ? ai_move : p_move;
    assign move_entry = move_mux(sel_move);
    assign dmg        = move_entry[7:4];
    assign accu       = move_entry[3:0];
    assign hit        = (accu_rng <= accu);

endmodule

// File: tb/tb_garo_move_unit.sv
// tb/tb_garo_move_unit.sv - directed self-checking bench for garo_move_unit

module tb_garo_move_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stop;
    logic       actr;
    logic [1:0] p_move;
    logic [1:0] ai_move;
    logic [3:0] accu_rng;
    logic [1:0] sel_move;
    logic [3:0] dmg;
    logic [3:0] accu;
    logic       hit;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0][15:0] m;
    logic [5:0][15:0] seeds;

    always #5 clk = ~clk;

    garo_move_unit dut (
        .clk      (clk),
        .rst      (rst),
        .stop     (stop),
        .actr     (actr),
        .p_move   (p_move),
        .ai_move  (ai_move),
        .accu_rng (accu_rng),
        .sel_move (sel_move),
        .dmg      (dmg),
        .accu     (accu),
        .hit      (hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] step16(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_adv();
        for (int k = 0; k < 6; k++) m[k] = step16(m[k]);
    endtask

    function automatic logic [1:0] exp_ai();
        return {m[1][0], m[0][0]};
    endfunction

    function automatic logic [3:0] exp_rng();
        return {m[5][0], m[4][0], m[3][0], m[2][0]};
    endfunction

    function automatic logic [3:0] exp_dmg(input logic [1:0] mv);
        case (mv)
            2'd0: return 4'd4;
            2'd1: return 4'd6;
            2'd2: return 4'd8;
            default: return 4'd11;
        endcase
    endfunction

    function automatic logic [3:0] exp_accu(input logic [1:0] mv);
        case (mv)
            2'd0: return 4'd15;
            2'd1: return 4'd12;
            2'd2: return 4'd9;
            default: return 4'd6;
        endcase
    endfunction

    initial begin
        int mism;
        int zeros;
        logic [1:0] mv;

        // Hand-computed seeds: ch0 = ACE1, chk = ACE1 ^ 1111*(k+1).
        seeds[0] = 16'hACE1;
        seeds[1] = 16'h8EC3;
        seeds[2] = 16'h9FD2;
        seeds[3] = 16'hE8A5;
        seeds[4] = 16'hF9B4;
        seeds[5] = 16'hCA87;

        rst = 1'b1; stop = 1'b0; actr = 1'b0; p_move = 2'd0;
        tick();
        tick();
        m = seeds;

        check("rst_ch0",      32'(dut.state_q[0]), 32'hACE1);
        check("rst_ch1",      32'(dut.state_q[1]), 32'h8EC3);
        check("rst_ai_move",  32'(ai_move),        32'd3);
        check("rst_accu_rng", 32'(accu_rng),       32'd10);

        // Roll is 10 while reset holds the seeds.
        p_move = 2'd3; #1;
        check("p3_hit", 32'(hit), 32'd0);
        check("p3_dmg", 32'(dmg), 32'd11);
        p_move = 2'd0; #1;
        check("p0_hit", 32'(hit), 32'd1);
        actr = 1'b1; #1;
        check("ai_sel_rst", 32'(sel_move), 32'd3);
        check("ai_hit_rst", 32'(hit),      32'd0);

        actr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p_move = 2'(i); #1;
            check($sformatf("sweep_sel%0d", i),  32'(sel_move), 32'(i));
            check($sformatf("sweep_dmg%0d", i),  32'(dmg),      32'(exp_dmg(2'(i))));
            check($sformatf("sweep_accu%0d", i), 32'(accu),     32'(exp_accu(2'(i))));
        end

        rst = 1'b0;
        tick();
        model_adv();
        check("step1_ch0",     32'(dut.state_q[0]), 32'hE270);
        check("step1_ai0",     32'(ai_move[0]),     32'd0);
        check("step1_ai_move", 32'(ai_move),        32'(exp_ai()));
        check("step1_rng",     32'(accu_rng),       32'(exp_rng()));

        // AI drives the selection; p_move is don't-care.
        actr = 1'b1; p_move = 2'bxx;
        for (int i = 0; i < 6; i++) begin
            tick();
            model_adv();
            mv = exp_ai();
            check($sformatf("ai_sel%0d", i),  32'(sel_move), 32'(mv));
            check($sformatf("ai_dmg%0d", i),  32'(dmg),      32'(exp_dmg(mv)));
            check($sformatf("ai_accu%0d", i), 32'(accu),     32'(exp_accu(mv)));
            check($sformatf("ai_hit%0d", i),  32'(hit),      32'(exp_rng() <= exp_accu(mv)));
        end
        actr = 1'b0; p_move = 2'd1;

        stop = 1'b1;
        mism = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int k = 0; k < 6; k++) if (dut.state_q[k] !== m[k]) mism++;
            if (ai_move !== exp_ai() || accu_rng !== exp_rng()) mism++;
        end
        check("stop_hold", 32'(mism), 32'd0);
        stop = 1'b0;
        tick();
        model_adv();
        check("resume_ch0", 32'(dut.state_q[0]), 32'(m[0]));
        check("resume_ch5", 32'(dut.state_q[5]), 32'(m[5]));
        check("resume_rng", 32'(accu_rng),       32'(exp_rng()));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m = seeds;
        mism = 0;
        zeros = 0;
        for (int i = 0; i < 65535; i++) begin
            tick();
            model_adv();
            if (ai_move !== exp_ai() || accu_rng !== exp_rng()) mism++;
            if (dut.state_q[0] == 16'h0000) zeros++;
        end
        check("period_ch0",   32'(dut.state_q[0]), 32'hACE1);
        check("period_zero",  32'(zeros),          32'd0);
        check("period_track", 32'(mism),           32'd0);

        // Advance off the seed, then reset while frozen.
        tick();
        stop = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rst_stop_ch%0d", k), 32'(dut.state_q[k]), 32'(seeds[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
